// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC sequencer: FSM state encoding and counter sizing helper.
package mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } mac_seq_state_t;

    // Drain counter holds PIPE_LAT-1, so it needs clog2(PIPE_LAT) bits (at least one).
    function automatic int drain_cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with zero and one flags; holds at zero instead of wrapping.
module mac_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a self-accumulating MAC PE: clear, stream K operand pairs, drain, return result.
// Optional overflow detection is built when MAC_SEQ_CTRL_OVF_EN is defined.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 8,
    parameter int PIPE_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_wt,
    output logic                  pe_reset,
    output logic                  pe_control,
    output logic [DATA_WIDTH-1:0] pe_data,
    output logic [DATA_WIDTH-1:0] pe_wt,
    input  logic [ACC_WIDTH-1:0]  pe_acc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
`ifdef MAC_SEQ_CTRL_OVF_EN
    ,
    output logic                  res_ovf
`endif
);

    localparam int                DRAIN_W    = drain_cnt_width(PIPE_LAT);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

    mac_seq_state_t state_q, state_d;
    logic [ACC_WIDTH-1:0] res_data_q;
    logic beat_load, beat_dec, beat_zero, beat_last;
    logic drain_load, drain_dec, drain_zero, drain_one;
    logic capture;

    mac_seq_cnt #(.W(LEN_WIDTH)) u_beat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (beat_load),
        .load_val_i (len),
        .dec_i      (beat_dec),
        .zero_o     (beat_zero),
        .one_o      (beat_last)
    );

    mac_seq_cnt #(.W(DRAIN_W)) u_drain_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (drain_load),
        .load_val_i (DRAIN_LOAD),
        .dec_i      (drain_dec),
        .zero_o     (drain_zero),
        .one_o      (drain_one)
    );

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        pe_control = 1'b0;
        pe_data    = '0;
        pe_wt      = '0;
        beat_load  = 1'b0;
        beat_dec   = 1'b0;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        capture    = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    beat_load = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (beat_zero) begin
                    drain_load = 1'b1;
                    state_d    = ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready   = 1'b1;
                pe_control = in_valid;
                pe_data    = in_data;
                pe_wt      = in_wt;
                if (in_valid) begin
                    beat_dec = 1'b1;
                    if (beat_last) begin
                        drain_load = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // drain_one is irrelevant here: the final cycle is the one where the count is zero
                if (drain_zero || (drain_one && 1'b0)) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                res_data_q <= pe_acc;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign pe_reset = (state_q == ST_CLEAR) | reset;
    assign res_data = res_data_q;

`ifdef MAC_SEQ_CTRL_OVF_EN
    // A single product never reaches 2^ACC_WIDTH, so any wrap shows up as a drop in pe_acc.
    logic [ACC_WIDTH-1:0] acc_prev_q, acc_prev_d;
    logic ovf_q, ovf_d, res_ovf_q, acc_drop;

    always_comb begin
        acc_drop   = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && (pe_acc < acc_prev_q);
        acc_prev_d = (state_q == ST_CLEAR) ? '0 : pe_acc;
        ovf_d      = (state_q == ST_CLEAR) ? 1'b0 : (ovf_q | acc_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_prev_q <= '0;
            ovf_q      <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            acc_prev_q <= acc_prev_d;
            ovf_q      <= ovf_d;
            if (capture) begin
                res_ovf_q <= ovf_q | acc_drop;
            end
        end
    end

    assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with an external self-accumulating PE model; build with MAC_SEQ_CTRL_OVF_EN for the overflow flag.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int PL = 1;
`ifdef MAC_SEQ_CTRL_OVF_EN
    localparam int AW = 16;
`else
    localparam int AW = 24;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] in_wt = '0;
    logic          pe_reset;
    logic          pe_control;
    logic [DW-1:0] pe_data;
    logic [DW-1:0] pe_wt;
    logic [AW-1:0] pe_acc;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
`ifdef MAC_SEQ_CTRL_OVF_EN
    logic          res_ovf;
`endif

    logic [DW-1:0] op_d [16];
    logic [DW-1:0] op_w [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .LEN_WIDTH  (LW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_wt      (in_wt),
        .pe_reset   (pe_reset),
        .pe_control (pe_control),
        .pe_data    (pe_data),
        .pe_wt      (pe_wt),
        .pe_acc     (pe_acc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
`ifdef MAC_SEQ_CTRL_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    // PE: one-cycle accumulate, acc_in tied to acc_out, synchronous clear.
    always @(posedge clk) begin
        if (pe_reset) begin
            pe_acc <= '0;
        end else if (pe_control) begin
            pe_acc <= pe_acc + AW'(pe_data) * AW'(pe_wt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact dot product of the first k pairs, before any wrap.
    function automatic longint ref_sum(input int k);
        longint s = 0;
        for (int i = 0; i < k; i++) begin
            s += longint'(op_d[i]) * longint'(op_w[i]);
        end
        return s;
    endfunction

    // Called just after a negedge in an IDLE cycle; leaves the bench just after a negedge in IDLE.
    task automatic run_job(input int k, input int bub_at, input int bub_len, input int hold);
        int cyc, b, bub_left, used, guard;
        longint s;
        logic [31:0] exp_data;
        s        = ref_sum(k);
        exp_data = 32'(s % (64'd1 << AW));
        start = 1'b1;
        len   = LW'(k);
        #1;
        chk("idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        #1;
        chk("clear_pe_reset", pe_reset, 1);
        chk("clear_in_ready", in_ready, 0);
        chk("clear_pe_control", pe_control, 0);
        chk("clear_busy", busy, 1);
        b = 0; bub_left = bub_len; used = 0; guard = 0;
        while (!res_valid && guard < 300) begin
            @(negedge clk);
            cyc++;
            guard++;
            if (b < k && b == bub_at && bub_left > 0) begin
                in_valid = 1'b0;
                bub_left--;
                used++;
            end else if (b < k) begin
                in_valid = 1'b1;
                in_data  = op_d[b];
                in_wt    = op_w[b];
            end else begin
                in_valid = 1'b0;
            end
            if (!in_valid) begin
                in_data = DW'($urandom);
                in_wt   = DW'($urandom);
            end
            #1;
            chk("in_ready", in_ready, b < k);
            chk("pe_control", pe_control, in_valid && (b < k));
            chk("pe_data", pe_data, (b < k) ? in_data : 0);
            chk("pe_wt", pe_wt, (b < k) ? in_wt : 0);
            chk("pe_reset_low", pe_reset, 0);
            if (in_valid) b++;
        end
        in_valid = 1'b0;
        chk("res_cycle", cyc, k + 2 + PL + used);
        chk("res_data", res_data, exp_data);
`ifdef MAC_SEQ_CTRL_OVF_EN
        chk("res_ovf", res_ovf, s >= (64'd1 << AW));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = (i == 1);
            len   = LW'(5);
            #1;
            chk("hold_res_data", res_data, exp_data);
            chk("hold_busy", busy, 1);
            chk("hold_res_valid", res_valid, 1);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("after_hs_busy", busy, 0);
        chk("after_hs_res_valid", res_valid, 0);
        if (hold > 0) begin
            @(negedge clk);
            #1;
            chk("start_ignored_busy", busy, 0);
        end
        $display("job k=%0d bubbles=%0d hold=%0d result=0x%0h latency=%0d", k, used, hold, res_data, cyc);
    endtask

    initial begin
        int k, ba, bl;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pe_control", pe_control, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_pe_reset", pe_reset, 1);
`ifdef MAC_SEQ_CTRL_OVF_EN
        chk("rst_res_ovf", res_ovf, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;

        op_d[0] = 8'd1; op_d[1] = 8'd2; op_d[2] = 8'd3;
        op_w[0] = 8'd4; op_w[1] = 8'd5; op_w[2] = 8'd6;
        run_job(3, -1, 0, 0);
        run_job(3, 1, 2, 0);
        run_job(0, -1, 0, 0);
        run_job(3, -1, 0, 5);

        // Reset during STREAM of a K=8 job
        for (int i = 0; i < 8; i++) begin
            op_d[i] = DW'($urandom);
            op_w[i] = DW'($urandom);
        end
        start = 1'b1;
        len   = LW'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = op_d[i];
            in_wt    = op_w[i];
        end
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_pe_control", pe_control, 0);
        chk("midrst_pe_reset", pe_reset, 1);
        chk("midrst_res_valid", res_valid, 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("postrst_busy", busy, 0);
        chk("postrst_res_valid", res_valid, 0);
        chk("postrst_pe_acc", pe_acc, 0);
        $display("reset mid-job: busy=%0d res_valid=%0d", busy, res_valid);

        op_d[0] = 8'd3; op_d[1] = 8'd3;
        op_w[0] = 8'd3; op_w[1] = 8'd3;
        run_job(2, -1, 0, 0);

        op_d[0] = 8'd255; op_d[1] = 8'd255;
        op_w[0] = 8'd255; op_w[1] = 8'd255;
        run_job(2, -1, 0, 0);
        op_d[0] = 8'd1;
        op_w[0] = 8'd1;
        run_job(1, -1, 0, 0);

        for (int j = 0; j < 6; j++) begin
            k  = int'($urandom_range(1, 12));
            ba = int'($urandom_range(0, 12));
            bl = int'($urandom_range(0, 3));
            for (int i = 0; i < k; i++) begin
                op_d[i] = DW'($urandom);
                op_w[i] = DW'($urandom);
            end
            run_job(k, ba, bl, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for one accumulating MAC processing element (PE) whose `acc_out` is fed back to its own `acc_in`. Accepts a job command carrying a vector length. Clears the PE, then streams operand pairs from an upstream valid/ready port into it while driving its `control` (accumulate) and `reset` (clear) inputs. Waits out the PE pipeline, then returns the dot product on a downstream valid/ready port.

## Interface
- `DATA_WIDTH`, 8, operand width; must match the PE.
- `ACC_WIDTH`, 24, accumulator width; must be ≥ 2*DATA_WIDTH.
- `LEN_WIDTH`, 8, width of the job length field.
- `PIPE_LAT`, 1, cycles from the last accumulate beat until `pe_acc` reflects it; must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: job request; sampled in IDLE only.
- `len` in LEN_WIDTH: number of operand pairs K, sampled with `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `in_valid` in 1, `in_ready` out 1: operand handshake.
- `in_data`, `in_wt` in DATA_WIDTH: operand pair.
- `pe_reset` out 1: PE clear.
- `pe_control` out 1: PE accumulate enable.
- `pe_data`, `pe_wt` out DATA_WIDTH: PE operands.
- `pe_acc` in ACC_WIDTH: PE `acc_out`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out ACC_WIDTH: registered result.
- `res_ovf` out 1: overflow flag; present only with MAC_SEQ_CTRL_OVF_EN.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - `start` = 1 → latch `len` into the beat counter, then go to CLEAR.
  - `start` outside IDLE is ignored; it is neither queued nor errored.
- CLEAR: one cycle with `pe_reset` = 1. Next state is STREAM if K > 0, else DRAIN.
- STREAM:
  - `in_ready` = 1.
  - `pe_data`/`pe_wt` are combinational copies of `in_data`/`in_wt`.
  - `pe_control` = `in_valid`.
  - A beat is `in_valid & in_ready`; each beat decrements the counter.
  - Non-beat cycles leave `pe_control` = 0, so the PE holds its value.
  - The beat that brings the counter to 0 moves the FSM to DRAIN.
- DRAIN:
  - Counts PIPE_LAT cycles.
  - On the final DRAIN cycle, register `pe_acc` into `res_data` and go to DONE.
- DONE: `res_valid` = 1. `res_valid & res_ready` → IDLE. `res_data` is stable while `res_valid` is high.
- Outside STREAM: `in_ready`, `pe_control`, `pe_data` and `pe_wt` are all 0.
- `pe_reset` = (state == CLEAR) | `reset`. The PE is therefore held clear throughout controller reset.
- Arithmetic: unsigned; the accumulator wraps modulo 2^ACC_WIDTH. The controller does no arithmetic on operands.

## Timing
- Reset values: state IDLE, counters 0, `busy` 0, `in_ready` 0, `pe_control` 0, `res_valid` 0, `res_data` 0, `res_ovf` 0. `pe_reset` is 1 while `reset` is high.
- With `start` in cycle 0:
  - CLEAR in cycle 1.
  - STREAM from cycle 2.
  - With `in_valid` held high, beats fall in cycles 2..K+1.
  - `res_valid` rises in cycle K+2+PIPE_LAT; for K=4, PIPE_LAT=1 that is cycle 7.
- Each `in_valid` bubble delays the result by exactly one cycle.
- K=0: `res_valid` in cycle 2+PIPE_LAT with `res_data` = 0.
- `res_ready` held high in the first DONE cycle → IDLE next cycle. A new `start` is accepted in that IDLE cycle.
- Reset asserted mid-job: immediate return to IDLE with all outputs at reset values. Any partial result is discarded.

## Configuration
- MAC_SEQ_CTRL_OVF_EN defined:
  - During STREAM and DRAIN, each cycle compares `pe_acc` against its previous-cycle sample.
  - Any decrease sets a sticky overflow bit; this is valid because a single product is < 2^ACC_WIDTH.
  - The bit is cleared in CLEAR and presented as `res_ovf` alongside `res_data`.
- Undefined: `res_ovf` port, sample register and compare logic are all absent.

## Structure
- Package `mac_seq_ctrl_pkg`:
  - State enum `mac_seq_state_t`.
  - Encodings for IDLE/CLEAR/STREAM/DRAIN/DONE.
- One sub-module, `mac_seq_cnt`: a loadable down-counter with a zero flag, instantiated twice (beat count, drain count).
- The PE is external; the bench instantiates the PE with `acc_in` tied to `acc_out`.

## Test plan
- K=3, data {1,2,3}, wt {4,5,6}, `in_valid` held high → `res_valid` in cycle 6, `res_data` = 32.
- Same job with `in_valid` low on the 2nd beat for 2 cycles → `res_data` = 32, `res_valid` in cycle 8, `pe_control` = 0 during the bubble.
- `len` = 0 → `res_data` = 0, `res_valid` in cycle 3; no `in_ready` pulse.
- `res_ready` low for 5 cycles in DONE, with `start` pulsed meanwhile → `res_data` stable, `busy` = 1, `start` ignored; IDLE after the handshake.
- `reset` pulsed during STREAM of a K=8 job → IDLE next edge, `res_valid` = 0; a new K=2 job {3,3}×{3,3} returns 18.
- ACC_WIDTH=16, OVF_EN defined, K=2, all operands 255 → `res_data` = 64514, `res_ovf` = 1. The next job, {1}×{1}, returns 1 with `res_ovf` = 0.
